// File: rtl/add_serial_sched_if.sv
// Bundle between the requesting control FSMs, the round-robin scheduler and
// the single shared 8-bit adder.
//   req/req_a/req_b : per-requester request level and operands (requester i
//                     owns req_a[i]/req_b[i], i.e. bits [8i+7:8i])
//   gnt/ack         : one-hot grant (whole transaction) and completion pulse
//   rsp_data/valid  : result and its one-cycle strobe
//   busy            : scheduler not idle
//   add_en/a/b/out  : shared adder start pulse, operands and result
// slave  = scheduler side, master = requester/adder side.
interface add_serial_sched_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0][7:0]  req_a;
  logic [N_REQ-1:0][7:0]  req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [7:0]             rsp_data;
  logic                   rsp_valid;
  logic                   busy;
  logic                   add_en;
  logic [7:0]             add_a;
  logic [7:0]             add_b;
  logic [7:0]             add_out;

  modport slave (
    input  req, req_a, req_b, add_out,
    output gnt, ack, rsp_data, rsp_valid, busy, add_en, add_a, add_b
  );

  modport master (
    output req, req_a, req_b, add_out,
    input  gnt, ack, rsp_data, rsp_valid, busy, add_en, add_a, add_b
  );
endinterface

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one fixed-latency 8-bit adder among N_REQ
// requesters. IDLE grants and latches operands, ISSUE pulses add_en, WAIT
// counts ADD_LAT cycles and captures add_out, RESP acks the granted requester
// and advances the round-robin pointer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : add_serial_sched_if.slave (requests, grant/ack, response,
//              shared adder port)
module add_serial_sched #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  add_serial_sched_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic [2:0]       id;
  logic [2:0]       ptr;
  logic [7:0]       cnt;
  logic [7:0]       rsp_data;
  logic [7:0]       add_a, add_b;
  logic             add_en, busy, rsp_valid;

  // Arbitration: first pass takes the lowest set bit at or above ptr, second
  // pass (only if the first found nothing) takes the lowest set bit overall,
  // which is the wrap-around part of the scan. Constant loop indices keep the
  // operand mux free of variable array indexing.
  logic             found;
  logic [2:0]       sel;
  logic [N_REQ-1:0] sel_oh;
  logic [7:0]       sel_a, sel_b;

  always_comb begin
    found  = 1'b0;
    sel    = '0;
    sel_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        sel       = 3'(i);
        sel_oh[i] = 1'b1;
        sel_a     = bus.req_a[i];
        sel_b     = bus.req_b[i];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[i]) begin
        found     = 1'b1;
        sel       = 3'(i);
        sel_oh[i] = 1'b1;
        sel_a     = bus.req_a[i];
        sel_b     = bus.req_b[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus outputs decoded from registered state only.
  always_comb begin
    state_nxt = state;
    add_en    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    ack       = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (found) state_nxt = ISSUE;
      end
      ISSUE: begin
        add_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 8'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        for (int i = 0; i < N_REQ; i++) ack[i] = (id == 3'(i));
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      id       <= '0;
      ptr      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      add_a    <= '0;
      add_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= sel_oh;
            id    <= sel;
            add_a <= sel_a;
            add_b <= sel_b;
          end
        end
        ISSUE: cnt <= 8'(ADD_LAT - 1);
        WAIT: begin
          // gnt drops on entry to RESP so it is low during the ack cycle.
          if (cnt == 8'd0) begin
            rsp_data <= bus.add_out;
            gnt      <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: ptr <= (id == 3'(N_REQ - 1)) ? 3'd0 : id + 3'd1;
        default: gnt <= '0;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.ack       = ack;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_valid = rsp_valid;
  assign bus.busy      = busy;
  assign bus.add_en    = add_en;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;

endmodule

// File: tb/tb_add_serial_sched.sv
module tb_add_serial_sched;
  localparam int N = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_serial_sched_if #(.N_REQ(N)) bus();
  add_serial_sched #(.N_REQ(N), .ADD_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural adder: result visible only in the cycle L cycles after add_en.
  logic [7:0] m_sum, m_cnt;
  logic       m_arm;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum <= 8'h00; m_cnt <= 8'h00; m_arm <= 1'b0;
    end else if (bus.add_en) begin
      m_sum <= bus.add_a + bus.add_b; m_cnt <= 8'(L - 1); m_arm <= 1'b1;
    end else if (m_arm) begin
      if (m_cnt == 8'h00) m_arm <= 1'b0;
      else                m_cnt <= m_cnt - 8'h01;
    end
  end
  assign bus.add_out = (m_arm && m_cnt == 8'h00) ? m_sum : 8'h00;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns the number of ticks until ack is seen, or -1 on timeout.
  task automatic wait_ack(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (|bus.ack) begin cyc = i + 1; return; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    rst = 1'b1; #1;
    checks++; if (bus.gnt !== 4'b0 || bus.ack !== 4'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got gnt=%b ack=%b busy=%b rv=%b exp all 0", bus.gnt, bus.ack, bus.busy, bus.rsp_valid); end
    checks++; if (bus.add_en !== 1'b0 || bus.add_a !== 8'h00 || bus.add_b !== 8'h00 || bus.rsp_data !== 8'h00) begin
      errors++; $display("FAIL reset_dp got en=%b a=%h b=%h d=%h exp 0", bus.add_en, bus.add_a, bus.add_b, bus.rsp_data); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0001; bus.req_a[0] = 8'h35; bus.req_b[0] = 8'h4A;   // c0
    tick();                                                          // c1
    checks++; if (bus.add_en !== 1'b1 || bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_c1 got en=%b gnt=%b busy=%b exp 1 0001 1", bus.add_en, bus.gnt, bus.busy); end
    checks++; if (bus.add_a !== 8'h35 || bus.add_b !== 8'h4A) begin
      errors++; $display("FAIL single_ops got a=%h b=%h exp 35 4a", bus.add_a, bus.add_b); end
    bus.req = 4'b0000;
    for (int c = 2; c <= 11; c++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0001 || bus.add_en !== 1'b0 || bus.ack !== 4'b0) begin
        errors++; $display("FAIL single_wait c%0d got gnt=%b en=%b ack=%b exp 0001 0 0000", c, bus.gnt, bus.add_en, bus.ack); end
    end
    tick();                                                          // c12
    checks++; if (bus.ack !== 4'b0001 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h7F || bus.gnt !== 4'b0) begin
      errors++; $display("FAIL single_resp got ack=%b rv=%b d=%h gnt=%b exp 0001 1 7f 0000", bus.ack, bus.rsp_valid, bus.rsp_data, bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_busy_c12 got %b exp 1", bus.busy); end
    tick();                                                          // c13
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_c13 got busy=%b ack=%b rv=%b exp 0 0000 0", bus.busy, bus.ack, bus.rsp_valid); end
  endtask

  task automatic test_overflow();
    int cyc;
    bus.req = 4'b0100; bus.req_a[2] = 8'hF0; bus.req_b[2] = 8'h20;
    wait_ack(20, cyc);
    bus.req = 4'b0000;
    checks++; if (cyc !== 12) begin
      errors++; $display("FAIL ovf_latency got %0d exp 12", cyc); end
    checks++; if (bus.ack !== 4'b0100 || bus.rsp_data !== 8'h10) begin
      errors++; $display("FAIL ovf_resp got ack=%b d=%h exp 0100 10", bus.ack, bus.rsp_data); end
    tick();
  endtask

  task automatic test_rr();
    logic [3:0] exp_ack [5];
    logic [7:0] exp_d   [5];
    int cyc;
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d   = '{8'h03, 8'h14, 8'h25, 8'h36, 8'h03};
    do_reset();
    bus.req_a = {8'h31, 8'h21, 8'h11, 8'h01};
    bus.req_b = {8'h05, 8'h04, 8'h03, 8'h02};
    bus.req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(20, cyc);
      if (k == 4) bus.req = 4'b0000;
      checks++; if (cyc !== ((k == 0) ? 12 : 13)) begin
        errors++; $display("FAIL rr_spacing%0d got %0d exp %0d", k, cyc, (k == 0) ? 12 : 13); end
      checks++; if (bus.ack !== exp_ack[k] || bus.rsp_data !== exp_d[k]) begin
        errors++; $display("FAIL rr_ack%0d got ack=%b d=%h exp %b %h", k, bus.ack, bus.rsp_data, exp_ack[k], exp_d[k]); end
    end
    tick();
  endtask

  task automatic test_ptr_wrap();
    int cyc;
    do_reset();
    bus.req_a = {8'h40, 8'h00, 8'h07, 8'h00};
    bus.req_b = {8'h02, 8'h00, 8'h01, 8'h00};
    bus.req = 4'b1000;
    wait_ack(20, cyc);
    checks++; if (bus.ack !== 4'b1000 || bus.rsp_data !== 8'h42) begin
      errors++; $display("FAIL wrap_first got ack=%b d=%h exp 1000 42", bus.ack, bus.rsp_data); end
    bus.req = 4'b1010;
    tick(); tick();                                                  // IDLE, then ISSUE
    checks++; if (bus.gnt !== 4'b0010) begin
      errors++; $display("FAIL wrap_gnt1 got %b exp 0010", bus.gnt); end
    wait_ack(20, cyc);
    checks++; if (bus.ack !== 4'b0010 || bus.rsp_data !== 8'h08) begin
      errors++; $display("FAIL wrap_ack1 got ack=%b d=%h exp 0010 08", bus.ack, bus.rsp_data); end
    tick(); tick();
    checks++; if (bus.gnt !== 4'b1000) begin
      errors++; $display("FAIL wrap_gnt2 got %b exp 1000", bus.gnt); end
    wait_ack(20, cyc);
    bus.req = 4'b0000;
    checks++; if (bus.ack !== 4'b1000 || cyc !== 11) begin
      errors++; $display("FAIL wrap_ack2 got ack=%b cyc=%0d exp 1000 11", bus.ack, cyc); end
    tick();
  endtask

  task automatic test_drop();
    bus.req = 4'b0001; bus.req_a[0] = 8'h01; bus.req_b[0] = 8'h02; // c0
    tick(); tick(); tick();                                          // c3
    bus.req = 4'b0000; bus.req_a[0] = 8'hFF;
    for (int c = 4; c <= 12; c++) tick();                            // c12
    checks++; if (bus.ack !== 4'b0001 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h03) begin
      errors++; $display("FAIL drop_resp got ack=%b rv=%b d=%h exp 0001 1 03", bus.ack, bus.rsp_valid, bus.rsp_data); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
      errors++; $display("FAIL drop_idle got busy=%b gnt=%b exp 0 0000", bus.busy, bus.gnt); end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    int cyc;
    bus.req = 4'b0001; bus.req_a[0] = 8'h11; bus.req_b[0] = 8'h22; // c0
    for (int c = 1; c <= 6; c++) tick();                             // c6
    checks++; if (bus.busy !== 1'b1 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL rstmid_pre got busy=%b gnt=%b exp 1 0001", bus.busy, bus.gnt); end
    rst = 1'b1; bus.req = 4'b0000; #1;
    checks++; if (bus.gnt !== 4'b0 || bus.ack !== 4'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.add_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl got gnt=%b ack=%b busy=%b rv=%b en=%b exp 0", bus.gnt, bus.ack, bus.busy, bus.rsp_valid, bus.add_en); end
    checks++; if (bus.add_a !== 8'h00 || bus.add_b !== 8'h00 || bus.rsp_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_dp got a=%h b=%h d=%h exp 0", bus.add_a, bus.add_b, bus.rsp_data); end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (|bus.ack || bus.rsp_valid) acks++;
    end
    checks++; if (acks !== 0) begin
      errors++; $display("FAIL rstmid_noack got %0d exp 0", acks); end
    bus.req = 4'b0100; bus.req_a[2] = 8'h0A; bus.req_b[2] = 8'h05;
    tick();
    checks++; if (bus.gnt !== 4'b0100 || bus.add_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt got gnt=%b en=%b exp 0100 1", bus.gnt, bus.add_en); end
    bus.req = 4'b0000;
    wait_ack(20, cyc);
    checks++; if (bus.ack !== 4'b0100 || bus.rsp_data !== 8'h0F || cyc !== 11) begin
      errors++; $display("FAIL rstmid_ack got ack=%b d=%h cyc=%0d exp 0100 0f 11", bus.ack, bus.rsp_data, cyc); end
    tick();
  endtask

  initial begin
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    test_reset();
    test_single();
    test_overflow();
    test_rr();
    test_ptr_wrap();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
